// File: rtl/rename_unit.sv
// Register alias table: maps architectural GPR/FPR registers to the ROB entry
// holding their newest pending value, translating decode operands combinationally.
module rename_unit #(
  parameter int unsigned ROB_DEPTH = 32,
  localparam int unsigned ROB = (ROB_DEPTH > 1) ? $clog2(ROB_DEPTH) : 1
) (
  input  logic           clk,
  input  logic           reset_,
  input  logic           flush_,
  input  logic           dec_e_,
  input  logic           dec_invalid,
  input  logic [6:0]     dec_rd,
  input  logic [6:0]     dec_rs1,
  input  logic [6:0]     dec_rs2,
  input  logic [ROB-1:0] dec_rob_id,
  output logic [6:0]     ren_rs1,
  output logic [6:0]     ren_rs2,
  output logic [6:0]     ren_rd,
  input  logic           commit_e_,
  input  logic [ROB-1:0] com_rob_id
);

  localparam int unsigned ADDR_W = 5;
  localparam int unsigned REG_W  = 7;
  localparam int unsigned IDX_W  = 6;
  localparam int unsigned N_ENT  = 64;

  localparam logic [1:0] TYPE_GPR = 2'd1;
  localparam logic [1:0] TYPE_FPR = 2'd2;
  localparam logic [1:0] TYPE_ROB = 2'd3;

  logic [N_ENT-1:0] valid_q;
  logic [ROB-1:0]   tag_q [N_ENT];

  logic [IDX_W-1:0] rs1_idx;
  logic [IDX_W-1:0] rs2_idx;
  logic [IDX_W-1:0] rd_idx;
  logic             rename_en;
  logic [N_ENT-1:0] commit_hit;

  // Only non-zero GPRs and all FPRs live in the map.
  function automatic logic renamable(input logic [REG_W-1:0] r);
    return ((r[6:5] == TYPE_GPR) && (r[4:0] != '0)) || (r[6:5] == TYPE_FPR);
  endfunction

  // FPR bank occupies the upper half of the table.
  function automatic logic [IDX_W-1:0] map_idx(input logic [REG_W-1:0] r);
    return {(r[6:5] == TYPE_FPR), r[4:0]};
  endfunction

  // Operand translation against the pre-edge map; no bypass of the current rd.
  always_comb begin
    rs1_idx = map_idx(dec_rs1);
    rs2_idx = map_idx(dec_rs2);
    rd_idx  = map_idx(dec_rd);
    ren_rs1 = dec_rs1;
    ren_rs2 = dec_rs2;
    ren_rd  = dec_rd;
    if (renamable(dec_rs1) && valid_q[rs1_idx]) begin
      ren_rs1 = {TYPE_ROB, ADDR_W'(tag_q[rs1_idx])};
    end
    if (renamable(dec_rs2) && valid_q[rs2_idx]) begin
      ren_rs2 = {TYPE_ROB, ADDR_W'(tag_q[rs2_idx])};
    end
    if (renamable(dec_rd)) begin
      ren_rd = {TYPE_ROB, ADDR_W'(dec_rob_id)};
    end
  end

  // Update strobes: new allocation and entries released by the committing id.
  always_comb begin
    rename_en  = !dec_e_ && !dec_invalid && renamable(dec_rd);
    commit_hit = '0;
    for (int i = 0; i < int'(N_ENT); i++) begin
      commit_hit[i] = !commit_e_ && valid_q[i] && (tag_q[i] == com_rob_id);
    end
  end

  // Flush beats rename and commit; rename beats commit on the same entry.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      valid_q <= '0;
      for (int i = 0; i < int'(N_ENT); i++) begin
        tag_q[i] <= '0;
      end
    end else if (!flush_) begin
      valid_q <= '0;
    end else begin
      for (int i = 0; i < int'(N_ENT); i++) begin
        if (commit_hit[i]) begin
          valid_q[i] <= 1'b0;
        end
      end
      if (rename_en) begin
        valid_q[rd_idx] <= 1'b1;
        tag_q[rd_idx]   <= dec_rob_id;
      end
    end
  end

endmodule

// File: tb/tb_rename_unit.sv
// Self-checking bench for rename_unit: directed scenarios plus a randomized run
// against an array-based reference map.
module tb_rename_unit;

  localparam logic [1:0] T_NONE = 2'd0;
  localparam logic [1:0] T_GPR  = 2'd1;
  localparam logic [1:0] T_FPR  = 2'd2;
  localparam logic [1:0] T_ROB  = 2'd3;

  logic       clk = 1'b0;
  logic       reset_;
  logic       flush_;
  logic       dec_e_;
  logic       dec_invalid;
  logic [6:0] dec_rd;
  logic [6:0] dec_rs1;
  logic [6:0] dec_rs2;
  logic [4:0] dec_rob_id;
  logic [6:0] ren_rs1;
  logic [6:0] ren_rs2;
  logic [6:0] ren_rd;
  logic       commit_e_;
  logic [4:0] com_rob_id;

  int errors = 0;
  int checks = 0;

  // Reference map: one pending flag and owning ROB id per architectural register.
  bit pend_gpr [32];
  int own_gpr  [32];
  bit pend_fpr [32];
  int own_fpr  [32];

  rename_unit #(.ROB_DEPTH(32)) dut (
    .clk        (clk),
    .reset_     (reset_),
    .flush_     (flush_),
    .dec_e_     (dec_e_),
    .dec_invalid(dec_invalid),
    .dec_rd     (dec_rd),
    .dec_rs1    (dec_rs1),
    .dec_rs2    (dec_rs2),
    .dec_rob_id (dec_rob_id),
    .ren_rs1    (ren_rs1),
    .ren_rs2    (ren_rs2),
    .ren_rd     (ren_rd),
    .commit_e_  (commit_e_),
    .com_rob_id (com_rob_id)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] mk(input logic [1:0] t, input int a);
    return {t, 5'(a)};
  endfunction

  function automatic logic [6:0] exp_src(input logic [6:0] s);
    int a = int'(s[4:0]);
    if (s[6:5] == T_GPR && a != 0 && pend_gpr[a]) return mk(T_ROB, own_gpr[a]);
    if (s[6:5] == T_FPR && pend_fpr[a]) return mk(T_ROB, own_fpr[a]);
    return s;
  endfunction

  function automatic logic [6:0] exp_dst(input logic [6:0] d, input logic [4:0] rob);
    if ((d[6:5] == T_GPR && d[4:0] != 5'd0) || d[6:5] == T_FPR) return mk(T_ROB, int'(rob));
    return d;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 32; i++) begin
      pend_gpr[i] = 1'b0; own_gpr[i] = 0;
      pend_fpr[i] = 1'b0; own_fpr[i] = 0;
    end
  endtask

  // What one clock edge does to the architectural map, given current inputs.
  task automatic model_edge();
    int a = int'(dec_rd[4:0]);
    if (!flush_) begin
      for (int i = 0; i < 32; i++) begin pend_gpr[i] = 1'b0; pend_fpr[i] = 1'b0; end
      return;
    end
    if (!commit_e_) begin
      for (int i = 0; i < 32; i++) begin
        if (pend_gpr[i] && own_gpr[i] == int'(com_rob_id)) pend_gpr[i] = 1'b0;
        if (pend_fpr[i] && own_fpr[i] == int'(com_rob_id)) pend_fpr[i] = 1'b0;
      end
    end
    if (!dec_e_ && !dec_invalid) begin
      if (dec_rd[6:5] == T_GPR && a != 0) begin pend_gpr[a] = 1'b1; own_gpr[a] = int'(dec_rob_id); end
      if (dec_rd[6:5] == T_FPR) begin pend_fpr[a] = 1'b1; own_fpr[a] = int'(dec_rob_id); end
    end
  endtask

  task automatic idle();
    flush_ = 1'b1; dec_e_ = 1'b1; dec_invalid = 1'b0; commit_e_ = 1'b1;
    dec_rd = '0; dec_rs1 = '0; dec_rs2 = '0; dec_rob_id = '0; com_rob_id = '0;
  endtask

  task automatic dec(input logic [6:0] rd, input logic [6:0] rs1, input logic [6:0] rs2,
                     input int rob);
    dec_e_ = 1'b0; dec_rd = rd; dec_rs1 = rs1; dec_rs2 = rs2; dec_rob_id = 5'(rob);
  endtask

  // Advance one edge, update the model, return to the falling edge for new stimulus.
  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    idle();
  endtask

  task automatic test_reset();
    idle();
    reset_ = 1'b0;
    model_clear();
    repeat (2) @(negedge clk);
    reset_ = 1'b1;
    dec(mk(T_NONE, 9), mk(T_GPR, 1), mk(T_FPR, 5), 3);
    #1;
    checks++;
    if (ren_rs1 !== mk(T_GPR, 1)) begin errors++; $display("FAIL reset_rs1: got %h want %h", ren_rs1, mk(T_GPR, 1)); end
    checks++;
    if (ren_rs2 !== mk(T_FPR, 5)) begin errors++; $display("FAIL reset_rs2: got %h want %h", ren_rs2, mk(T_FPR, 5)); end
    checks++;
    if (ren_rd !== mk(T_NONE, 9)) begin errors++; $display("FAIL reset_rd_none: got %h want %h", ren_rd, mk(T_NONE, 9)); end
    idle();
  endtask

  task automatic test_basic();
    dec(mk(T_GPR, 1), mk(T_NONE, 0), mk(T_NONE, 0), 4);
    step();
    dec(mk(T_GPR, 0), mk(T_GPR, 1), mk(T_GPR, 2), 9);
    #1;
    checks++;
    if (ren_rs1 !== mk(T_ROB, 4)) begin errors++; $display("FAIL basic_rs1: got %h want %h", ren_rs1, mk(T_ROB, 4)); end
    checks++;
    if (ren_rs2 !== mk(T_GPR, 2)) begin errors++; $display("FAIL basic_rs2: got %h want %h", ren_rs2, mk(T_GPR, 2)); end
    checks++;
    if (ren_rd !== mk(T_GPR, 0)) begin errors++; $display("FAIL basic_rd_x0: got %h want %h", ren_rd, mk(T_GPR, 0)); end
    step();
    dec(mk(T_NONE, 0), mk(T_GPR, 0), mk(T_GPR, 1), 0);
    #1;
    checks++;
    if (ren_rs1 !== mk(T_GPR, 0)) begin errors++; $display("FAIL x0_not_renamed: got %h want %h", ren_rs1, mk(T_GPR, 0)); end
    checks++;
    if (ren_rs2 !== mk(T_ROB, 4)) begin errors++; $display("FAIL x0_no_map_change: got %h want %h", ren_rs2, mk(T_ROB, 4)); end
    idle();
  endtask

  task automatic test_commit();
    dec(mk(T_GPR, 1), mk(T_NONE, 0), mk(T_NONE, 0), 5);
    step();
    dec_rs1 = mk(T_GPR, 1);
    #1;
    checks++;
    if (ren_rs1 !== mk(T_ROB, 5)) begin errors++; $display("FAIL remap_x1: got %h want %h", ren_rs1, mk(T_ROB, 5)); end
    commit_e_ = 1'b0; com_rob_id = 5'd4;
    step();
    dec_rs1 = mk(T_GPR, 1);
    #1;
    checks++;
    if (ren_rs1 !== mk(T_ROB, 5)) begin errors++; $display("FAIL stale_commit: got %h want %h", ren_rs1, mk(T_ROB, 5)); end
    commit_e_ = 1'b0; com_rob_id = 5'd5;
    step();
    dec_rs1 = mk(T_GPR, 1);
    #1;
    checks++;
    if (ren_rs1 !== mk(T_GPR, 1)) begin errors++; $display("FAIL commit_release: got %h want %h", ren_rs1, mk(T_GPR, 1)); end
    idle();
  endtask

  task automatic test_flush();
    dec(mk(T_GPR, 1), mk(T_NONE, 0), mk(T_NONE, 0), 8);
    step();
    dec(mk(T_GPR, 2), mk(T_NONE, 0), mk(T_NONE, 0), 6);
    step();
    flush_ = 1'b0;
    dec_rs1 = mk(T_GPR, 1); dec_rs2 = mk(T_GPR, 2);
    #1;
    checks++;
    if (ren_rs2 !== mk(T_ROB, 6)) begin errors++; $display("FAIL during_flush_rs2: got %h want %h", ren_rs2, mk(T_ROB, 6)); end
    step();
    dec_rs1 = mk(T_GPR, 1); dec_rs2 = mk(T_GPR, 2);
    #1;
    checks++;
    if (ren_rs1 !== mk(T_GPR, 1)) begin errors++; $display("FAIL flush_x1: got %h want %h", ren_rs1, mk(T_GPR, 1)); end
    checks++;
    if (ren_rs2 !== mk(T_GPR, 2)) begin errors++; $display("FAIL flush_x2: got %h want %h", ren_rs2, mk(T_GPR, 2)); end
    dec(mk(T_GPR, 2), mk(T_NONE, 0), mk(T_NONE, 0), 6);
    flush_ = 1'b0;
    step();
    dec_rs2 = mk(T_GPR, 2);
    #1;
    checks++;
    if (ren_rs2 !== mk(T_GPR, 2)) begin errors++; $display("FAIL flush_beats_rename: got %h want %h", ren_rs2, mk(T_GPR, 2)); end
    idle();
  endtask

  task automatic test_invalid_fpr();
    dec(mk(T_GPR, 3), mk(T_NONE, 0), mk(T_NONE, 0), 9);
    dec_invalid = 1'b1;
    step();
    dec_rs1 = mk(T_GPR, 3);
    #1;
    checks++;
    if (ren_rs1 !== mk(T_GPR, 3)) begin errors++; $display("FAIL invalid_no_update: got %h want %h", ren_rs1, mk(T_GPR, 3)); end
    dec(mk(T_FPR, 3), mk(T_NONE, 0), mk(T_NONE, 0), 10);
    step();
    dec_rs1 = mk(T_GPR, 3); dec_rs2 = mk(T_FPR, 3);
    #1;
    checks++;
    if (ren_rs1 !== mk(T_GPR, 3)) begin errors++; $display("FAIL fpr_bank_x3: got %h want %h", ren_rs1, mk(T_GPR, 3)); end
    checks++;
    if (ren_rs2 !== mk(T_ROB, 10)) begin errors++; $display("FAIL fpr_bank_f3: got %h want %h", ren_rs2, mk(T_ROB, 10)); end
    dec(mk(T_GPR, 3), mk(T_NONE, 0), mk(T_NONE, 0), 11);
    step();
    dec_rs1 = mk(T_GPR, 3); dec_rs2 = mk(T_FPR, 3);
    #1;
    checks++;
    if (ren_rs1 !== mk(T_ROB, 11)) begin errors++; $display("FAIL gpr_bank_x3: got %h want %h", ren_rs1, mk(T_ROB, 11)); end
    checks++;
    if (ren_rs2 !== mk(T_ROB, 10)) begin errors++; $display("FAIL fpr_untouched: got %h want %h", ren_rs2, mk(T_ROB, 10)); end
    idle();
  endtask

  task automatic test_same_cycle();
    dec(mk(T_GPR, 1), mk(T_NONE, 0), mk(T_NONE, 0), 4);
    step();
    dec(mk(T_GPR, 1), mk(T_GPR, 1), mk(T_NONE, 0), 7);
    commit_e_ = 1'b0; com_rob_id = 5'd4;
    #1;
    checks++;
    if (ren_rs1 !== mk(T_ROB, 4)) begin errors++; $display("FAIL no_rd_bypass: got %h want %h", ren_rs1, mk(T_ROB, 4)); end
    checks++;
    if (ren_rd !== mk(T_ROB, 7)) begin errors++; $display("FAIL rd_tag: got %h want %h", ren_rd, mk(T_ROB, 7)); end
    step();
    dec_rs1 = mk(T_GPR, 1);
    #1;
    checks++;
    if (ren_rs1 !== mk(T_ROB, 7)) begin errors++; $display("FAIL rename_beats_commit: got %h want %h", ren_rs1, mk(T_ROB, 7)); end
    idle();
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      logic [6:0] rd;
      logic [6:0] rs1;
      logic [6:0] rs2;
      rd  = mk(2'($urandom_range(0, 3)), int'($urandom_range(0, 7)));
      rs1 = mk(2'($urandom_range(0, 3)), int'($urandom_range(0, 7)));
      rs2 = mk(2'($urandom_range(0, 3)), int'($urandom_range(0, 7)));
      dec(rd, rs1, rs2, int'($urandom_range(0, 31)));
      dec_e_      = ($urandom_range(0, 9) < 3);
      dec_invalid = ($urandom_range(0, 9) == 0);
      flush_      = ($urandom_range(0, 19) != 0);
      commit_e_   = ($urandom_range(0, 9) < 6);
      com_rob_id  = 5'($urandom_range(0, 31));
      #1;
      checks++;
      if (ren_rs1 !== exp_src(rs1)) begin errors++; $display("FAIL rand_rs1 #%0d: got %h want %h", n, ren_rs1, exp_src(rs1)); end
      checks++;
      if (ren_rs2 !== exp_src(rs2)) begin errors++; $display("FAIL rand_rs2 #%0d: got %h want %h", n, ren_rs2, exp_src(rs2)); end
      checks++;
      if (ren_rd !== exp_dst(rd, dec_rob_id)) begin errors++; $display("FAIL rand_rd #%0d: got %h want %h", n, ren_rd, exp_dst(rd, dec_rob_id)); end
      step();
    end
  endtask

  task automatic test_async_reset();
    dec(mk(T_FPR, 7), mk(T_NONE, 0), mk(T_NONE, 0), 12);
    step();
    dec(mk(T_GPR, 4), mk(T_NONE, 0), mk(T_NONE, 0), 13);
    step();
    dec_rs1 = mk(T_FPR, 7); dec_rs2 = mk(T_GPR, 4);
    #1;
    checks++;
    if (ren_rs1 !== mk(T_ROB, 12)) begin errors++; $display("FAIL pre_reset_f7: got %h want %h", ren_rs1, mk(T_ROB, 12)); end
    #1 reset_ = 1'b0;
    model_clear();
    #1;
    checks++;
    if (ren_rs1 !== mk(T_FPR, 7)) begin errors++; $display("FAIL async_reset_f7: got %h want %h", ren_rs1, mk(T_FPR, 7)); end
    checks++;
    if (ren_rs2 !== mk(T_GPR, 4)) begin errors++; $display("FAIL async_reset_x4: got %h want %h", ren_rs2, mk(T_GPR, 4)); end
    @(negedge clk);
    reset_ = 1'b1;
    idle();
  endtask

  initial begin
    idle();
    reset_ = 1'b0;
    model_clear();
    @(negedge clk);
    test_reset();
    test_basic();
    test_commit();
    test_flush();
    test_invalid_fpr();
    test_same_cycle();
    test_random();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rename_unit.md
Name: rename_unit

Overview:
- Register-rename map (register alias table) for the out-of-order core's decode/dispatch stage.
- For each architectural GPR/FPR it tracks whether a ROB entry holds the newest pending value. If so, it records that entry's id.
- Source operands are translated to ROB tags when pending. The destination is tagged with the allocating ROB id.
- Entries are released on commit and cleared wholesale on pipeline flush.

Parameters:
- ROB_DEPTH, 32, number of ROB entries; ROB = clog2(ROB_DEPTH) is the ROB id width. Must be ≤ 32 so an id fits in RegFile_t.addr.

Ports:
- clk  in  1  system clock, rising edge.
- reset_  in  1  asynchronous, active-low reset.
- flush_  in  1  active-low pipeline flush.
- dec_e_  in  1  active-low decode-valid strobe.
- dec_invalid  in  1  active-high; decoded instruction is illegal, so no map update.
- dec_rd  in  RegFile_t  destination architectural register.
- dec_rs1  in  RegFile_t  source 1.
- dec_rs2  in  RegFile_t  source 2.
- dec_rob_id  in  ROB  ROB entry allocated to this instruction.
- ren_rs1  out  RegFile_t  renamed source 1.
- ren_rs2  out  RegFile_t  renamed source 2.
- ren_rd  out  RegFile_t  renamed destination.
- commit_e_  in  1  active-low commit strobe.
- com_rob_id  in  ROB  id of the committing ROB entry.
- RegFile_t is the packed struct from regfile.svh: {regtype[1:0], addr[4:0]}. The regtype values are TYPE_NONE=0, TYPE_GPR=1, TYPE_FPR=2, TYPE_ROB=3.

Behaviour:
- State: 64 map entries (32 GPR, 32 FPR). Each entry holds a valid bit and a ROB-bit tag.
- Reset (reset_ low, asynchronous): all valid bits are cleared and tags are set to 0.
- Outputs are combinational, with zero-cycle latency from dec_* inputs to ren_*.
- Source translation (rs1, rs2 independently):
  - If regtype is GPR or FPR, the addressed entry is valid, and the register is not GPR x0: output {TYPE_ROB, tag}.
  - Otherwise the source passes through unchanged.
  - A lookup sees only the state from before the current edge. There is no same-cycle bypass of the current rd; rs1 = rd of the same instruction reads the old mapping.
- Destination translation:
  - If rd is GPR (addr≠0) or FPR: ren_rd = {TYPE_ROB, dec_rob_id}.
  - Otherwise ren_rd = dec_rd unchanged.
- Rename update (rising edge):
  - Condition: dec_e_=0, dec_invalid=0, flush_=1, and rd is GPR≠x0 or FPR.
  - Action: set entry[rd].valid=1 and entry[rd].tag=dec_rob_id, overwriting any older mapping.
- Commit (rising edge, commit_e_=0):
  - Every valid entry whose tag equals com_rob_id is cleared.
  - Entries that have since been remapped to another id are untouched.
  - If commit and rename target the same entry in one cycle, the rename wins (valid=1, new tag).
- Flush (flush_=0, synchronous at the rising edge): all valid bits are cleared.
  - Flush has priority over a same-cycle rename and over a same-cycle commit; the rename is discarded.
  - Outputs stay combinationally driven during flush.
- Reset mid-operation: asynchronous clear overrides everything.
- The map holds state while dec_e_ and commit_e_ are both high.
- x0 is never renamed.
- TYPE_NONE operands always pass through.
- Mapping lookup and update use regtype to select between the GPR and FPR banks.

Test Plan:
- Reset, then dec rd=GPR x1, rob_id=4 (one cycle). Next dec rs1=GPR1, rs2=GPR2, rd=GPR0 -> ren_rs1={ROB,4}, ren_rs2={GPR,2}, ren_rd={GPR,0}, and no map change.
- Remap x1 to rob_id=5, then read rs1=x1 -> {ROB,5}. Commit com_rob_id=4 -> x1 still {ROB,5}. Commit 5 -> x1 reads {GPR,1}.
- Rename x2 to rob 6, then assert flush_ for one cycle -> rs1=x1 and rs2=x2 read {GPR,1} and {GPR,2}.
- Rename rd=x2, rob 6 in the same cycle as flush_=0 -> afterwards x2 reads {GPR,2}; the mapping is not recorded.
- Rename with dec_invalid=1, and rename of FPR f3 vs GPR x3 -> invalid leaves the map unchanged. FPR f3 maps independently of GPR x3.
- Rename and commit of the same register in one cycle (x1: old rob 4 committing, new rob 7) -> x1 reads {ROB,7}. Asynchronous reset asserted mid-sequence -> all sources pass through.
